// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the register-file write port, with
// youngest-first forwarding of pending writes to two read ports.
module wb_write_queue #(
    parameter  int DataWidth  = 32,
    parameter  int NumEntries = 31,
    parameter  int Depth      = 4,
    localparam int AddrWidth  = $clog2(NumEntries),
    localparam int CountWidth = $clog2(Depth) + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [AddrWidth-1:0]  in_addr_i,
    input  logic [DataWidth-1:0]  in_data_i,
    input  logic                  hold_i,
    output logic                  wr_valid_o,
    output logic [AddrWidth-1:0]  wr_addr_o,
    output logic [DataWidth-1:0]  wr_data_o,
    input  logic [AddrWidth-1:0]  rs1_addr_i,
    output logic                  fwd1_hit_o,
    output logic [DataWidth-1:0]  fwd1_data_o,
    input  logic [AddrWidth-1:0]  rs2_addr_i,
    output logic                  fwd2_hit_o,
    output logic [DataWidth-1:0]  fwd2_data_o,
    output logic [CountWidth-1:0] count_o
);

    localparam int PtrWidth = $clog2(Depth);

    logic [AddrWidth-1:0]  addr_q [Depth];
    logic [DataWidth-1:0]  data_q [Depth];
    logic [Depth-1:0]      valid_q;
    logic [PtrWidth-1:0]   head_q;
    logic [PtrWidth-1:0]   tail_q;
    logic [CountWidth-1:0] count_q;

    logic push;
    logic pop;

    // Writes to x0 complete the handshake but are never stored.
    assign in_ready_o = (count_q < CountWidth'(Depth));
    assign push       = in_valid_i && in_ready_o && (in_addr_i != '0);
    assign wr_valid_o = (count_q != '0) && !hold_i;
    assign pop        = wr_valid_o;
    assign count_o    = count_q;

    assign wr_addr_o = valid_q[head_q] ? addr_q[head_q] : '0;
    assign wr_data_o = valid_q[head_q] ? data_q[head_q] : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                tail_q          <= tail_q + 1'b1;
                valid_q[tail_q] <= 1'b1;
            end
            if (pop) begin
                head_q          <= head_q + 1'b1;
                valid_q[head_q] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: payload storage has no reset; valid_q gates every read of it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[tail_q] <= in_addr_i;
            data_q[tail_q] <= in_data_i;
        end
    end

    // Walk oldest to youngest from the head so the last match is the youngest.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        logic [PtrWidth-1:0] idx;
        idx         = '0;
        fwd1_hit_o  = 1'b0;
        fwd1_data_o = '0;
        fwd2_hit_o  = 1'b0;
        fwd2_data_o = '0;
        for (int i = 0; i < Depth; i++) begin
            idx = head_q + PtrWidth'(i);
            if (valid_q[idx] && (rs1_addr_i != '0) && (addr_q[idx] == rs1_addr_i)) begin
                fwd1_hit_o  = 1'b1;
                fwd1_data_o = data_q[idx];
            end
            if (valid_q[idx] && (rs2_addr_i != '0) && (addr_q[idx] == rs2_addr_i)) begin
                fwd2_hit_o  = 1'b1;
                fwd2_data_o = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: a reference queue predicts count, ready,
// drain contents and forwarding every cycle.
module tb_wb_write_queue;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 3;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk_i;
    logic          reset_ni;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [AW-1:0] in_addr_i;
    logic [DW-1:0] in_data_i;
    logic          hold_i;
    logic          wr_valid_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic [AW-1:0] rs1_addr_i;
    logic          fwd1_hit_o;
    logic [DW-1:0] fwd1_data_o;
    logic [AW-1:0] rs2_addr_i;
    logic          fwd2_hit_o;
    logic [DW-1:0] fwd2_data_o;
    logic [CW-1:0] count_o;

    int checks = 0;
    int errors = 0;
    entry_t exp_q[$];

    wb_write_queue dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_addr_i  (in_addr_i),
        .in_data_i  (in_data_i),
        .hold_i     (hold_i),
        .wr_valid_o (wr_valid_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .rs1_addr_i (rs1_addr_i),
        .fwd1_hit_o (fwd1_hit_o),
        .fwd1_data_o(fwd1_data_o),
        .rs2_addr_i (rs2_addr_i),
        .fwd2_hit_o (fwd2_hit_o),
        .fwd2_data_o(fwd2_data_o),
        .count_o    (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void fwd_model(input logic [AW-1:0] a, output logic hit,
                                      output logic [DW-1:0] data);
        hit  = 1'b0;
        data = '0;
        foreach (exp_q[i]) begin
            if (a != '0 && exp_q[i].addr == a) begin
                hit  = 1'b1;
                data = exp_q[i].data;
            end
        end
    endfunction

    // Inputs are already driven; settle, compare against the model, then clock.
    task automatic step();
        logic          exp_valid;
        logic          accept;
        logic          h;
        logic [DW-1:0] d;
        entry_t        e;
        #1;
        check("count", 64'(count_o), 64'(exp_q.size()));
        check("in_ready", 64'(in_ready_o), 64'(exp_q.size() < DEPTH));
        exp_valid = (exp_q.size() != 0) && !hold_i;
        check("wr_valid", 64'(wr_valid_o), 64'(exp_valid));
        if (exp_q.size() != 0) begin
            check("wr_addr", 64'(wr_addr_o), 64'(exp_q[0].addr));
            check("wr_data", 64'(wr_data_o), 64'(exp_q[0].data));
        end else begin
            check("wr_addr_empty", 64'(wr_addr_o), 64'd0);
            check("wr_data_empty", 64'(wr_data_o), 64'd0);
        end
        fwd_model(rs1_addr_i, h, d);
        check("fwd1_hit", 64'(fwd1_hit_o), 64'(h));
        check("fwd1_data", 64'(fwd1_data_o), 64'(d));
        fwd_model(rs2_addr_i, h, d);
        check("fwd2_hit", 64'(fwd2_hit_o), 64'(h));
        check("fwd2_data", 64'(fwd2_data_o), 64'(d));
        accept = in_valid_i && (exp_q.size() < DEPTH);
        if (exp_valid) void'(exp_q.pop_front());
        if (accept && in_addr_i != '0) begin
            e.addr = in_addr_i;
            e.data = in_data_i;
            exp_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid_i = v;
        in_addr_i  = a;
        in_data_i  = d;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
    endtask

    initial begin
        reset_ni   = 1'b0;
        in_valid_i = 1'b0;
        in_addr_i  = '0;
        in_data_i  = '0;
        hold_i     = 1'b0;
        rs1_addr_i = '0;
        rs2_addr_i = '0;
        #12;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_ready", 64'(in_ready_o), 64'd1);
        check("rst_wr_valid", 64'(wr_valid_o), 64'd0);
        check("rst_wr_data", 64'(wr_data_o), 64'd0);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single write into an empty queue drains for exactly one cycle.
        drive(1'b1, 5'd5, 32'hDEADBEEF);
        idle(3);

        // Fill while held; the fifth request is refused.
        hold_i = 1'b1;
        for (int i = 1; i <= 4; i++) drive(1'b1, AW'(i), 32'hA0 + 32'(i));
        drive(1'b1, 5'd9, 32'h99);
        check("full_not_ready", 64'(in_ready_o), 64'd0);
        hold_i = 1'b0;
        idle(6);

        // Youngest matching entry wins the forward.
        hold_i     = 1'b1;
        rs1_addr_i = 5'd7;
        drive(1'b1, 5'd7, 32'h1);
        drive(1'b1, 5'd7, 32'h2);
        drive(1'b0, '0, '0);
        check("fwd_youngest", 64'(fwd1_data_o), 64'h2);
        hold_i = 1'b0;
        idle(4);
        check("fwd_after_drain", 64'(fwd1_hit_o), 64'd0);

        // Writes to x0 are accepted but dropped.
        rs2_addr_i = '0;
        drive(1'b1, 5'd0, 32'hFFFF);
        idle(2);

        // Back-to-back traffic with continuous drain wraps the pointers.
        rs1_addr_i = 5'd3;
        rs2_addr_i = 5'd12;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, AW'(10 + i), 32'h1000 + 32'(i));
            check("wrap_count_le1", 64'(count_o <= 1), 64'd1);
        end
        idle(3);

        // Reset mid-traffic discards pending entries immediately.
        hold_i     = 1'b1;
        rs1_addr_i = 5'd20;
        drive(1'b1, 5'd20, 32'h55);
        drive(1'b1, 5'd21, 32'h66);
        drive(1'b1, 5'd22, 32'h77);
        #2;
        reset_ni = 1'b0;
        #1;
        check("midrst_count", 64'(count_o), 64'd0);
        check("midrst_wr_valid", 64'(wr_valid_o), 64'd0);
        check("midrst_ready", 64'(in_ready_o), 64'd1);
        check("midrst_wr_addr", 64'(wr_addr_o), 64'd0);
        check("midrst_fwd", 64'(fwd1_hit_o), 64'd0);
        exp_q.delete();
        hold_i     = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
        idle(2);

        // Random traffic over a small address range to exercise forwarding.
        for (int i = 0; i < 300; i++) begin
            hold_i     = ($urandom_range(0, 3) == 0);
            rs1_addr_i = AW'($urandom_range(0, 7));
            rs2_addr_i = AW'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
        end
        hold_i = 1'b0;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
